// File: rtl/conv_pkg.sv
// Stage encodings and widths shared by the convolution stage controller
// and the weight cache.
package conv_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_INIT    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_ROW_0   = 3'd2,
    ST_ROW_1   = 3'd3,
    ST_ROW_2   = 3'd4,
    ST_BIAS    = 3'd5,
    ST_LOAD    = 3'd6,
    ST_IDLE    = 3'd7
  } stage_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_phase_timer.sv
// Loadable down-counter with a zero flag; times every stage of the
// convolution stage controller.
module conv_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Saturates at zero so a counter left idle never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/conv_stage_ctrl.sv
// Stage sequencer for the convolution engine: PRELOAD, then per output row
// ROW_0..ROW_2 and BIAS, with LOAD between rows. Optional macro
// CONV_STAGE_CTRL_HOLD_EN adds an i_hold input that freezes a running job.
module conv_stage_ctrl
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ARRAY_SIZE  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
`ifdef CONV_STAGE_CTRL_HOLD_EN
  input  logic         i_hold,
`endif
  output logic [2:0]   o_current_state,
  output logic [2:0]   o_row_idx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int MAX_DUR = max_int(IMAGE_SIZE, KERNEL_SIZE);
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam logic [CNT_W-1:0] IMG_LD  = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] KER_LD  = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [2:0]       LAST_ROW = 3'(ARRAY_SIZE - 1);

  stage_e           r_state;
  stage_e           r_out_state;
  logic [2:0]       r_row_idx;
  stage_e           w_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic             w_hold;

`ifdef CONV_STAGE_CTRL_HOLD_EN
  assign w_hold = i_hold && (r_state != ST_INIT) && (r_state != ST_IDLE);
`else
  assign w_hold = 1'b0;
`endif

  conv_phase_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (!w_hold),
    .o_zero     (w_zero)
  );

  // Stage transitions; the timer is reloaded with the new stage's duration minus one.
  always_comb begin
    w_next = r_state;
    if (!w_hold) begin
      case (r_state)
        ST_INIT, ST_IDLE: if (i_start) w_next = ST_PRELOAD;
        ST_PRELOAD:       if (w_zero) w_next = ST_ROW_0;
        ST_ROW_0:         if (w_zero) w_next = ST_ROW_1;
        ST_ROW_1:         if (w_zero) w_next = ST_ROW_2;
        ST_ROW_2:         if (w_zero) w_next = ST_BIAS;
        ST_BIAS:          if (w_zero) w_next = (r_row_idx < LAST_ROW) ? ST_LOAD : ST_IDLE;
        ST_LOAD:          if (w_zero) w_next = ST_ROW_0;
        default:          w_next = ST_INIT;
      endcase
    end
    w_load = (w_next != r_state);
    case (w_next)
      ST_PRELOAD, ST_LOAD:          w_load_val = IMG_LD;
      ST_ROW_0, ST_ROW_1, ST_ROW_2: w_load_val = KER_LD;
      default:                      w_load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_out_state <= ST_INIT;
      r_row_idx   <= 3'd0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_state <= w_hold ? ST_IDLE : w_next;
      o_done      <= 1'b0;
      if (w_load && (w_next == ST_PRELOAD)) begin
        r_row_idx <= 3'd0;
        o_busy    <= 1'b1;
      end
      if ((r_state == ST_LOAD) && (w_next == ST_ROW_0)) begin
        r_row_idx <= r_row_idx + 3'd1;
      end
      if (w_load && (w_next == ST_IDLE)) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

  assign o_current_state = r_out_state;
  assign o_row_idx       = r_row_idx;

endmodule

// File: tb/tb_conv_stage_ctrl.sv
// Scoreboard bench for conv_stage_ctrl; the hold scenario is exercised only
// when CONV_STAGE_CTRL_HOLD_EN is defined.
`timescale 1ns/1ps
module tb_conv_stage_ctrl;

  localparam int ARR      = 6;
  localparam int IMG      = 8;
  localparam int JOB_LAT  = 108;
  localparam int ROW_CYC  = 10;
  localparam int JOB_ROWS = 60;
  localparam int HOLD_CYC = 5;
  localparam int S_INIT = 0, S_PRE = 1, S_ROW0 = 2, S_ROW1 = 3, S_ROW2 = 4;
  localparam int S_BIAS = 5, S_LOAD = 6, S_IDLE = 7;

  typedef struct {
    int startEdge;
    int latency;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
`ifdef CONV_STAGE_CTRL_HOLD_EN
  logic       i_hold;
`endif
  logic [2:0] o_current_state;
  logic [2:0] o_row_idx;
  logic       o_busy;
  logic       o_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   seg = 0;
  int   total = 0;
  int   prevState = 0;
  exp_t sb[$];

  conv_stage_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
`ifdef CONV_STAGE_CTRL_HOLD_EN
    .i_hold          (i_hold),
`endif
    .o_current_state (o_current_state),
    .o_row_idx       (o_row_idx),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Pulse i_start for one cycle from a falling edge and record the job's expected latency.
  task automatic applyStimulus(input int latency);
    exp_t e;
    e.startEdge = cyc + 1;
    e.latency   = latency;
    sb.push_back(e);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic waitFor(input int st, input int row, input int budget, input string name);
    int n = 0;
    while (!((int'(o_current_state) == st) && (row < 0 || int'(o_row_idx) == row)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(o_current_state), st);
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(o_done), 1);
  endtask

  // Monitor: row-phase cycle accounting and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      seg   = 0;
      total = 0;
      prevState = S_INIT;
    end else begin
      if (int'(o_current_state) == S_PRE) begin
        seg   = 0;
        total = 0;
      end
      if (int'(o_current_state) inside {[S_ROW0:S_BIAS]}) begin
        seg++;
        total++;
      end
      if (int'(o_current_state) == S_LOAD && prevState != S_LOAD) begin
        checkOutput("rowSegment", seg, ROW_CYC);
        seg = 0;
      end
      if (o_done) begin
        checkOutput("doneExpected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("doneLatency", cyc - e.startEdge, e.latency);
          checkOutput("doneBusy", int'(o_busy), 0);
          checkOutput("doneRowIdx", int'(o_row_idx), ARR - 1);
          checkOutput("lastSegment", seg, ROW_CYC);
          checkOutput("jobRowTotal", total, JOB_ROWS);
        end
        seg   = 0;
        total = 0;
      end
      prevState = int'(o_current_state);
    end
  end

  initial begin
    exp_t e;
    rst_n   = 1'b0;
    i_start = 1'b0;
`ifdef CONV_STAGE_CTRL_HOLD_EN
    i_hold  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("resetState", int'(o_current_state), S_INIT);
    checkOutput("resetRowIdx", int'(o_row_idx), 0);
    checkOutput("resetBusy", int'(o_busy), 0);
    checkOutput("resetDone", int'(o_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("initAfterReset", int'(o_current_state), S_INIT);

    // Single start pulse: PRELOAD for 8 cycles, ROW_0 on cycle 9.
    applyStimulus(JOB_LAT);
    for (int i = 1; i <= IMG; i++) begin
      checkOutput("preloadState", int'(o_current_state), S_PRE);
      @(negedge clk);
    end
    checkOutput("row0AtCycle9", int'(o_current_state), S_ROW0);
    checkOutput("busyInJob", int'(o_busy), 1);
    waitDone(200, "job1Done");
    @(negedge clk);
    checkOutput("idleAfterDone", int'(o_current_state), S_IDLE);
    checkOutput("donePulseOnly", int'(o_done), 0);

    // i_start held high: no restart mid-job, second job begins from IDLE.
    e.startEdge = cyc + 1;
    e.latency   = JOB_LAT;
    sb.push_back(e);
    e.startEdge = cyc + 1 + JOB_LAT + 1;
    sb.push_back(e);
    i_start = 1'b1;
    @(negedge clk);
    checkOutput("heldStartPreload", int'(o_current_state), S_PRE);
    waitDone(200, "heldJobDone");
    @(negedge clk);
    checkOutput("restartFromIdle", int'(o_current_state), S_PRE);
    checkOutput("restartBusy", int'(o_busy), 1);
    i_start = 1'b0;
    waitDone(200, "secondJobDone");
    @(negedge clk);

    // Asynchronous reset in ROW_1 of row 3, away from any rising edge.
    applyStimulus(JOB_LAT);
    waitFor(S_ROW1, 3, 200, "reachRow1Row3");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetState", int'(o_current_state), S_INIT);
    checkOutput("asyncResetRowIdx", int'(o_row_idx), 0);
    checkOutput("asyncResetBusy", int'(o_busy), 0);
    checkOutput("asyncResetDone", int'(o_done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("initAfterMidReset", int'(o_current_state), S_INIT);
    applyStimulus(JOB_LAT);
    waitDone(200, "jobAfterReset");
    @(negedge clk);

`ifdef CONV_STAGE_CTRL_HOLD_EN
    // Hold for 5 cycles in the middle of ROW_2 of row 0.
    applyStimulus(JOB_LAT + HOLD_CYC);
    waitFor(S_ROW2, 0, 50, "reachRow2");
    @(negedge clk);
    i_hold = 1'b1;
    for (int i = 0; i < HOLD_CYC; i++) begin
      @(negedge clk);
      checkOutput("holdShowsIdle", int'(o_current_state), S_IDLE);
      checkOutput("holdBusy", int'(o_busy), 1);
    end
    i_hold = 1'b0;
    @(negedge clk);
    checkOutput("holdResumeRow2", int'(o_current_state), S_ROW2);
    @(negedge clk);
    checkOutput("holdThenBias", int'(o_current_state), S_BIAS);
    waitDone(200, "holdJobDone");
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_stage_ctrl.md
CONV_STAGE_CTRL -- requirements
Module: conv_stage_ctrl

Interface
REQ-001 SHALL declare parameter IMAGE_SIZE, default 8, input image width/height in pixels.
REQ-002 SHALL declare parameter KERNEL_SIZE, default 3, kernel width/height.
REQ-003 SHALL declare parameter ARRAY_SIZE, default 6, PE count, equal to IMAGE_SIZE-KERNEL_SIZE+1 (the output rows per job).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  job request, sampled on the rising edge.
REQ-007 SHALL have port o_current_state  output  3  stage code driving the weight cache and data path.
REQ-008 SHALL have port o_row_idx  output  3  index of the output row being computed, 0..ARRAY_SIZE-1.
REQ-009 SHALL have port o_busy  output  1  high from start acceptance until IDLE is entered.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse on job completion.

Function
REQ-011 SHALL encode stages as INIT=0, PRELOAD=1, ROW_0=2, ROW_1=3, ROW_2=4, BIAS=5, LOAD=6, IDLE=7.
REQ-012 SHALL accept i_start only in INIT or IDLE, entering PRELOAD on that edge; start in any other state is ignored.
REQ-013 SHALL hold PRELOAD for IMAGE_SIZE cycles, then enter ROW_0.
REQ-014 SHALL hold each of ROW_0, ROW_1 and ROW_2 for KERNEL_SIZE cycles, in that order.
REQ-015 SHALL hold BIAS for exactly 1 cycle.
REQ-016 SHALL, after BIAS, enter LOAD if o_row_idx < ARRAY_SIZE-1, otherwise enter IDLE.
REQ-017 SHALL hold LOAD for IMAGE_SIZE cycles, increment o_row_idx on LOAD exit, and then enter ROW_0.
REQ-018 SHALL produce exactly 3*KERNEL_SIZE+1 consecutive cycles of ROW_0..BIAS per output row, so the downstream weight address advances exactly 10 times per row with the defaults.
REQ-019 SHALL register all outputs directly from flops.
  - o_current_state equals the state register (no extra latency).
REQ-020 SHALL assert o_done for exactly the first cycle in IDLE.
  - o_busy low in that same cycle.
REQ-021 SHALL, with default parameters, reach IDLE 108 cycles after the accepting edge.
  - Breakdown: 8 PRELOAD + 6*10 row cycles + 5*8 LOAD.
REQ-022 SHALL reset o_row_idx to 0 whenever PRELOAD is entered.
REQ-023 SHALL use per-phase cycle counters wide enough for max(IMAGE_SIZE, KERNEL_SIZE)-1 and clear them at every stage transition.
  - Counters never wrap within a stage.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-job, immediately drive all outputs to their reset values.
  - o_current_state=INIT, o_row_idx=0, o_busy=0, o_done=0; all counters 0.
REQ-025 SHALL resume normal operation on the first rising edge after rst_n deasserts, waiting in INIT for i_start.

Configuration
REQ-026 SHALL support macro CONV_STAGE_CTRL_HOLD_EN.
  - Defined: adds port i_hold (input, 1), declared after i_start.
  - While i_hold is high: the state, counters and o_row_idx freeze, o_current_state reads IDLE (weight address holds), o_busy stays high, and o_done is not asserted.
  - On release: o_current_state returns to the frozen stage and its remaining cycle count continues.
  - i_hold is ignored in INIT and IDLE.
REQ-027 SHALL, without CONV_STAGE_CTRL_HOLD_EN, have no i_hold port and behave as if i_hold=0.

Structure
REQ-028 SHALL take the stage encodings and the 3-bit stage width from shared package conv_pkg, also used by the weight cache.
REQ-029 SHALL instantiate one sub-module, conv_phase_timer: a loadable down-counter with a zero flag, reused for every stage duration.

Verification
REQ-030 Bench SHALL cover: reset, then i_start pulse -> PRELOAD for 8 cycles, ROW_0 on cycle 9, o_done high exactly 108 cycles after the start edge, o_row_idx reaching 5.
REQ-031 Bench SHALL cover: i_start held high during a job -> no restart; 108-cycle timing unchanged; a new job starts from IDLE when i_start is high there.
REQ-032 Bench SHALL cover: rst_n pulled low in ROW_1 of row 3 -> outputs at reset values without waiting for a clock edge; next i_start runs a full 108-cycle job.
REQ-033 Bench SHALL cover: count of cycles with o_current_state in 2..5 between LOADs equals 10, and the total over a job equals 60.
REQ-034 Bench SHALL cover, with HOLD_EN: i_hold high for 5 cycles in the middle of ROW_2 -> IDLE shown for 5 cycles, ROW_2 resumes with its remaining cycles, and done arrives at 113 cycles.
